// File: rtl/hazard_stall_ctrl.sv
// Stall/flush control for the F/D/E pipeline registers: tracks in-flight destinations with
// their Tnew in E and M, plus mult/div busy time, and stalls the D instruction when needed.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] D_dst,
  input  logic [1:0] D_tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_md_use,
  output logic       stall,
  output logic       F_WE,
  output logic       D_WE,
  output logic       E_clr
);

  logic [4:0]       e_dst_q, e_dst_d;
  logic [1:0]       e_tnew_q, e_tnew_d;
  logic             e_md_q, e_md_d;
  logic             e_div_q, e_div_d;
  logic [4:0]       m_dst_q, m_dst_d;
  logic [1:0]       m_tnew_q, m_tnew_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic rs_hazard, rt_hazard, md_hazard, hazard;

  // A tuse of 3 means the operand is not read; register 0 never carries a dependency.
  always_comb begin
    rs_hazard = (D_rs != 5'd0) && (D_tuse_rs != 2'd3) &&
                (((e_dst_q == D_rs) && (D_tuse_rs < e_tnew_q)) ||
                 ((m_dst_q == D_rs) && (D_tuse_rs < m_tnew_q)));
    rt_hazard = (D_rt != 5'd0) && (D_tuse_rt != 2'd3) &&
                (((e_dst_q == D_rt) && (D_tuse_rt < e_tnew_q)) ||
                 ((m_dst_q == D_rt) && (D_tuse_rt < m_tnew_q)));
    md_hazard = D_md_use && ((md_cnt_q != '0) || e_md_q);
    hazard    = rs_hazard || rt_hazard || md_hazard;
  end

  always_comb begin
    stall = ~reset & hazard;
    F_WE  = ~stall;
    D_WE  = ~stall;
    E_clr = stall;
  end

  always_comb begin
    e_dst_d  = D_dst;
    e_tnew_d = D_tnew;
    e_md_d   = D_md_start;
    e_div_d  = D_md_start & D_md_div;
    if (hazard) begin
      e_dst_d  = 5'd0;
      e_tnew_d = 2'd0;
      e_md_d   = 1'b0;
      e_div_d  = 1'b0;
    end
    // M advances from E regardless of the stall.
    m_dst_d  = e_dst_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    md_cnt_d = md_cnt_q;
    if (e_md_q) begin
      md_cnt_d = e_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_dst_q  <= 5'd0;
      e_tnew_q <= 2'd0;
      e_md_q   <= 1'b0;
      e_div_q  <= 1'b0;
      m_dst_q  <= 5'd0;
      m_tnew_q <= 2'd0;
      md_cnt_q <= '0;
    end else begin
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      e_md_q   <= e_md_d;
      e_div_q  <= e_div_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule
